// File: rtl/centroid_ctrl.sv
// centroid_ctrl: binary-mask centroid engine.
// Counts pixel position from de/vsync, accumulates mask moments per frame,
// and at each vsync rising edge divides the moments with an external
// divider to produce the centroid (xcent, ycent).
// Optional divider watchdog: define CENTROID_DIV_TIMEOUT_EN.
module centroid_ctrl #(
    parameter int unsigned IMG_W       = 1280,
    parameter int unsigned IMG_H       = 720,
    parameter int unsigned DIV_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic        vsync,
    input  logic        pix,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [19:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic        div_done,
    output logic [10:0] xcent,
    output logic [9:0]  ycent,
    output logic        cent_valid,
    output logic        div_timeout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIV_X  = 3'd1,
        WAIT_X = 3'd2,
        DIV_Y  = 3'd3,
        WAIT_Y = 3'd4,
        UPDATE = 3'd5
    } state_t;

    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [9:0]  Y_LAST = 10'(IMG_H - 1);

    state_t      state, state_nxt;
    logic        vsync_d;
    logic        eof;
    logic [10:0] x_pos;
    logic [9:0]  y_pos;
    logic [19:0] m;
    logic [31:0] m_x, m_y;
    logic [19:0] sh_m;
    logic [31:0] sh_mx, sh_my;
    logic [10:0] qx;
    logic [9:0]  qy;
    logic [10:0] qx_clamp;
    logic [9:0]  qy_clamp;
    logic        ld_shadow, issue_x, issue_y, take_x, take_y, do_update;
    logic        timeout_hit;

    assign eof = vsync & ~vsync_d;

    assign qx_clamp = (div_quotient > 32'(X_LAST)) ? X_LAST : div_quotient[10:0];
    assign qy_clamp = (div_quotient > 32'(Y_LAST)) ? Y_LAST : div_quotient[9:0];

    // Previous-vsync register for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_d <= 1'b0;
        else        vsync_d <= vsync;
    end

    // Raster position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (vsync) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (de) begin
            if (x_pos == X_LAST) begin
                x_pos <= '0;
                y_pos <= (y_pos == Y_LAST) ? '0 : y_pos + 10'd1;
            end else begin
                x_pos <= x_pos + 11'd1;
            end
        end
    end

    // Moment accumulators, cleared at every eof whatever the FSM is doing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            m_x <= '0;
            m_y <= '0;
        end else if (eof) begin
            m   <= '0;
            m_x <= '0;
            m_y <= '0;
        end else if (de && pix) begin
            m   <= m + 20'd1;
            m_x <= m_x + 32'(x_pos);
            m_y <= m_y + 32'(y_pos);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state and datapath control strobes
    always_comb begin
        state_nxt = state;
        ld_shadow = 1'b0;
        issue_x   = 1'b0;
        issue_y   = 1'b0;
        take_x    = 1'b0;
        take_y    = 1'b0;
        do_update = 1'b0;
        case (state)
            IDLE: begin
                if (eof && (m != '0)) begin
                    ld_shadow = 1'b1;
                    state_nxt = DIV_X;
                end
            end
            DIV_X: begin
                issue_x   = 1'b1;
                state_nxt = WAIT_X;
            end
            WAIT_X: begin
                if (div_done) begin
                    take_x    = 1'b1;
                    state_nxt = DIV_Y;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            DIV_Y: begin
                issue_y   = 1'b1;
                state_nxt = WAIT_Y;
            end
            WAIT_Y: begin
                if (div_done) begin
                    take_y    = 1'b1;
                    state_nxt = UPDATE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            UPDATE: begin
                do_update = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow snapshot of the finished frame's moments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_m  <= '0;
            sh_mx <= '0;
            sh_my <= '0;
        end else if (ld_shadow) begin
            sh_m  <= m;
            sh_mx <= m_x;
            sh_my <= m_y;
        end
    end

    // Divider request; operands held until the next request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            div_start <= issue_x | issue_y;
            if (issue_x) begin
                div_dividend <= sh_mx;
                div_divisor  <= sh_m;
            end else if (issue_y) begin
                div_dividend <= sh_my;
                div_divisor  <= sh_m;
            end
        end
    end

    // Clamped quotient capture and centroid output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qx         <= '0;
            qy         <= '0;
            xcent      <= '0;
            ycent      <= '0;
            cent_valid <= 1'b0;
        end else begin
            if (take_x) qx <= qx_clamp;
            if (take_y) qy <= qy_clamp;
            cent_valid <= do_update;
            if (do_update) begin
                xcent <= qx;
                ycent <= qy;
            end
        end
    end

`ifdef CENTROID_DIV_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_flag;

    assign timeout_hit = ((state == WAIT_X) || (state == WAIT_Y)) && !div_done &&
                         (wd_cnt == 32'(DIV_TIMEOUT - 1));
    assign div_timeout = wd_flag;

    // Watchdog: counts cycles spent waiting on the divider; flag is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            if ((state == WAIT_X) || (state == WAIT_Y)) begin
                if (div_done || timeout_hit) wd_cnt <= '0;
                else                         wd_cnt <= wd_cnt + 32'd1;
            end else begin
                wd_cnt <= '0;
            end
            if (timeout_hit) wd_flag <= 1'b1;
        end
    end
`else
    logic [31:0] unused_div_timeout;

    assign unused_div_timeout = 32'(DIV_TIMEOUT);
    assign timeout_hit        = 1'b0;
    assign div_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_centroid_ctrl.sv
// tb_centroid_ctrl: directed bench for centroid_ctrl with an 8-cycle divider model.
module tb_centroid_ctrl;

    localparam int W = 128;
    localparam int H = 64;
    localparam int LAT = 21;

    logic        clk = 1'b0;
    logic        rst_n, de, vsync, pix;
    logic        div_start, div_done, cent_valid, div_timeout;
    logic [31:0] div_dividend;
    logic [31:0] div_quotient = '0;
    logic [19:0] div_divisor;
    logic [10:0] xcent;
    logic [9:0]  ycent;

    int n_chk  = 0;
    int n_fail = 0;

    centroid_ctrl #(.IMG_W(W), .IMG_H(H), .DIV_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .de(de), .vsync(vsync), .pix(pix),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_done(div_done),
        .xcent(xcent), .ycent(ycent), .cent_valid(cent_valid), .div_timeout(div_timeout)
    );

    always #5 clk = ~clk;

    // Divider model: done is sampled 8 edges after div_start is seen
    int          dcnt = 0;
    logic        div_en = 1'b1;
    logic        stab_en = 1'b1;
    logic [31:0] dv_n = '0;
    logic [19:0] dv_d = '0;
    int          stab_viol = 0;

    assign div_done = (dcnt == 1);

    always @(posedge clk) begin
        if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (stab_en && ((div_dividend != dv_n) || (div_divisor != dv_d)))
                stab_viol <= stab_viol + 1;
        end
        if (div_start && div_en) begin
            dcnt         <= 8;
            dv_n         <= div_dividend;
            dv_d         <= div_divisor;
            div_quotient <= div_dividend / 32'(div_divisor);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_box(input int x0, input int x1, input int y0, input int y1,
                             input int lines);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < W; x++) begin
                @(negedge clk);
                de  = 1'b1;
                pix = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
            end
        end
        @(negedge clk);
        de  = 1'b0;
        pix = 1'b0;
    endtask

    task automatic run_eof(input int budget, output int lat, output int nv, output int ns);
        lat = -1;
        nv  = 0;
        ns  = 0;
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) vsync = 1'b0;
            if (cent_valid) begin
                nv++;
                if (lat < 0) lat = k;
            end
            if (div_start) ns++;
        end
    endtask

    typedef struct {
        int   x0, x1, y0, y1, lines;
        logic valid;
        int   ex, ey;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, nv, ns, k_to;

        vecs[0] = '{100, 100, 50, 50, 51, 1'b1, 100, 50};
        vecs[1] = '{10, 11, 20, 21, 22, 1'b1, 10, 20};
        vecs[2] = '{1, 0, 0, 0, 2, 1'b0, 10, 20};
        vecs[3] = '{5, 6, 7, 9, 10, 1'b1, 5, 8};
        vecs[4] = '{127, 127, 63, 63, 64, 1'b1, 127, 63};
        vecs[5] = '{0, 3, 0, 0, 1, 1'b1, 1, 0};

        rst_n = 1'b0;
        de    = 1'b0;
        vsync = 1'b0;
        pix   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_xcent", int'(xcent), 0);
        check("rst_ycent", int'(ycent), 0);
        check("rst_cent_valid", int'(cent_valid), 0);
        check("rst_div_start", int'(div_start), 0);
        check("rst_div_dividend", int'(div_dividend), 0);
        check("rst_div_divisor", int'(div_divisor), 0);
        check("rst_div_timeout", int'(div_timeout), 0);
        rst_n = 1'b1;

        run_eof(40, lat, nv, ns);
        check("init_eof_starts", ns, 0);
        check("init_eof_valid", nv, 0);

        for (int i = 0; i < 6; i++) begin
            drive_box(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].lines);
            run_eof(40, lat, nv, ns);
            if (vecs[i].valid) begin
                check($sformatf("v%0d_latency", i), lat, LAT);
                check($sformatf("v%0d_valid_pulses", i), nv, 1);
                check($sformatf("v%0d_div_starts", i), ns, 2);
            end else begin
                check($sformatf("v%0d_valid_pulses", i), nv, 0);
                check($sformatf("v%0d_div_starts", i), ns, 0);
            end
            check($sformatf("v%0d_xcent", i), int'(xcent), vecs[i].ex);
            check($sformatf("v%0d_ycent", i), int'(ycent), vecs[i].ey);
        end

        // Second eof while waiting on the x divide: only the first frame reports
        drive_box(20, 20, 3, 3, 4);
        lat = -1;
        nv  = 0;
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) vsync = 1'b0;
            if (k >= 3 && k <= 6) begin
                de  = 1'b1;
                pix = 1'b1;
            end
            if (k == 7) begin
                de    = 1'b0;
                pix   = 1'b0;
                vsync = 1'b1;
            end
            if (k == 9) vsync = 1'b0;
            if (cent_valid) begin
                nv++;
                if (lat < 0) lat = k;
            end
        end
        check("dbl_eof_latency", lat, LAT);
        check("dbl_eof_valid_pulses", nv, 1);
        check("dbl_eof_xcent", int'(xcent), 20);
        check("dbl_eof_ycent", int'(ycent), 3);
        run_eof(40, lat, nv, ns);
        check("dbl_eof_dropped_starts", ns, 0);
        check("dbl_eof_dropped_valid", nv, 0);
        check("divider_operand_stability", stab_viol, 0);

        // Reset during the y divide; the late div_done must be ignored
        drive_box(3, 3, 2, 2, 3);
        nv = 0;
        ns = 0;
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) vsync = 1'b0;
            if (k == 14) begin
                stab_en = 1'b0;
                rst_n   = 1'b0;
            end
            if (k == 15) begin
                check("midrst_xcent", int'(xcent), 0);
                check("midrst_ycent", int'(ycent), 0);
                check("midrst_div_start", int'(div_start), 0);
                check("midrst_div_dividend", int'(div_dividend), 0);
                check("midrst_div_divisor", int'(div_divisor), 0);
                check("midrst_state_idle", int'(dut.state), 0);
            end
            if (k == 17) rst_n = 1'b1;
            if (k >= 17) begin
                if (cent_valid) nv++;
                if (div_start) ns++;
            end
        end
        check("midrst_late_done_valid", nv, 0);
        check("midrst_late_done_starts", ns, 0);
        stab_en = 1'b1;

        // First eof after reset release is honoured
        drive_box(50, 50, 10, 10, 11);
        run_eof(40, lat, nv, ns);
        check("postrst_latency", lat, LAT);
        check("postrst_xcent", int'(xcent), 50);
        check("postrst_ycent", int'(ycent), 10);

`ifdef CENTROID_DIV_TIMEOUT_EN
        // Divider never answers: watchdog fires after 16 waiting cycles
        div_en = 1'b0;
        drive_box(7, 7, 5, 5, 6);
        k_to = -1;
        nv   = 0;
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) vsync = 1'b0;
            if (div_timeout && k_to < 0) k_to = k;
            if (cent_valid) nv++;
        end
        check("wdog_fire_cycle", k_to, 17);
        check("wdog_valid_pulses", nv, 0);
        check("wdog_flag_sticky", int'(div_timeout), 1);
        check("wdog_state_idle", int'(dut.state), 0);
        check("wdog_xcent_hold", int'(xcent), 50);
        check("wdog_ycent_hold", int'(ycent), 10);
`else
        k_to = 0;
        check("no_wdog_flag", int'(div_timeout), k_to);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
